// File: rtl/rx_pkg.sv
// Shared types and constants for the UART receive bit-timing sequencer.
// No logic here; consumed by rx_bit_scheduler and its interface.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        BIT   = 2'd2,
        DONE  = 2'd3
    } rx_sched_state_t;

    // Smallest legal bit period; anything below is replaced by DEFAULT_DIV.
    localparam int MIN_DIV      = 4;
    localparam int LEAD_DEFAULT = 2;

endpackage

// File: rtl/rx_bit_scheduler_if.sv
// Control/status bundle between the receiver control unit (master) and the scheduler (slave).
// Pure wiring, zero latency; no backpressure, the scheduler follows enable_timer level.
interface rx_bit_scheduler_if #(
    parameter int DIV_W = 8
);

    logic             enable_timer;
    logic [DIV_W-1:0] clk_div;
    logic             shift_strobe;
    logic             packet_done;
    logic             busy;
    logic             cfg_error;

    modport master (
        output enable_timer,
        output clk_div,
        input  shift_strobe,
        input  packet_done,
        input  busy,
        input  cfg_error
    );

    modport slave (
        input  enable_timer,
        input  clk_div,
        output shift_strobe,
        output packet_done,
        output busy,
        output cfg_error
    );

endinterface

// File: rtl/sched_counter.sv
// Interval counter with programmable rollover; hit is combinational, roll is hit delayed one clock.
// Clear wins over count_enable; no backpressure.
module sched_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] rollover,
    output logic         hit,
    output logic         roll
);

    logic [W-1:0] cnt;

    // Terminal count is rollover-1 so an interval of N clocks spans cnt = 0..N-1.
    assign hit = count_en && !clear && (cnt == rollover - W'(1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt  <= '0;
            roll <= 1'b0;
        end else begin
            roll <= hit;
            if (clear) begin
                cnt <= '0;
            end else if (count_en) begin
                cnt <= hit ? '0 : cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_bit_scheduler.sv
// UART RX bit-timing sequencer: mid-bit shift strobes and frame-done flag while enable_timer is high.
// Strobes/cfg_error are registered; first strobe first_len+1 clocks after enable; dropping enable aborts next edge.
module rx_bit_scheduler
    import rx_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10,
    parameter int DATA_BITS   = 8,
    parameter int LEAD        = LEAD_DEFAULT
) (
    input  logic              clk,
    input  logic              n_rst,
    rx_bit_scheduler_if.slave sched
);

    localparam int CW     = DIV_W + 1;
    localparam int BCNT_W = $clog2(DATA_BITS + 1);

    // The first interval is shortened by LEAD and must still leave room for a gap between strobes.
    if (MIN_DIV + (MIN_DIV / 2) - LEAD < MIN_DIV) begin : g_lead_check
        $error("LEAD too large for MIN_DIV: first interval would fall below MIN_DIV");
    end
    if (DEFAULT_DIV < MIN_DIV) begin : g_default_check
        $error("DEFAULT_DIV must be at least MIN_DIV");
    end

    rx_sched_state_t   state;
    rx_sched_state_t   state_nxt;
    logic [DIV_W-1:0]  div;
    logic [BCNT_W-1:0] bcnt;
    logic [CW-1:0]     first_len;
    logic [CW-1:0]     rollover;
    logic              start;
    logic              div_legal;
    logic              last_bit;
    logic              cnt_en;
    logic              cnt_clr;
    logic              hit;
    logic              roll;
    logic              cfg_error_q;

    assign start     = (state == IDLE) && sched.enable_timer;
    assign div_legal = (sched.clk_div >= DIV_W'(MIN_DIV));
    assign last_bit  = (bcnt == BCNT_W'(DATA_BITS));

    // Start-bit edge detection already consumed LEAD clocks of the 1.5-bit first interval.
    assign first_len = CW'(div) + CW'(div >> 1) - CW'(LEAD);
    assign rollover  = (state == FIRST) ? first_len : CW'(div);

    assign cnt_en  = sched.enable_timer && ((state == FIRST) || (state == BIT));
    assign cnt_clr = !cnt_en;

    sched_counter #(
        .W (CW)
    ) u_interval (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clr),
        .count_en (cnt_en),
        .rollover (rollover),
        .hit      (hit),
        .roll     (roll)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sched.enable_timer) state_nxt = FIRST;
            end
            FIRST: begin
                if (!sched.enable_timer) state_nxt = IDLE;
                else if (hit)            state_nxt = BIT;
            end
            BIT: begin
                if (!sched.enable_timer)   state_nxt = IDLE;
                else if (hit && last_bit)  state_nxt = DONE;
            end
            DONE: begin
                if (!sched.enable_timer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sched.busy        = (state != IDLE);
        sched.packet_done = (state == DONE);
    end

    assign sched.shift_strobe = roll;
    assign sched.cfg_error    = cfg_error_q;

    // Divisor is captured once per frame so mid-frame clk_div edits cannot skew bit timing.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div         <= DIV_W'(DEFAULT_DIV);
            bcnt        <= '0;
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= start && !div_legal;
            if (start) begin
                div <= div_legal ? sched.clk_div : DIV_W'(DEFAULT_DIV);
            end
            if (!cnt_en) begin
                bcnt <= '0;
            end else if (hit) begin
                if (state == FIRST) begin
                    bcnt <= BCNT_W'(1);
                end else if (!last_bit) begin
                    bcnt <= bcnt + BCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_bit_scheduler.sv
// Directed bench for rx_bit_scheduler: reset, nominal, illegal divisor, abort, config change, back-to-back.
module tb_rx_bit_scheduler;

    logic clk = 1'b0;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    rx_bit_scheduler_if #(.DIV_W(8)) sif ();

    rx_bit_scheduler #(
        .DIV_W       (8),
        .DEFAULT_DIV (10),
        .DATA_BITS   (8),
        .LEAD        (2)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .sched (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " shift_strobe"}, sif.shift_strobe, 0);
        check({tag, " packet_done"},  sif.packet_done,  0);
        check({tag, " busy"},         sif.busy,         0);
        check({tag, " cfg_error"},    sif.cfg_error,    0);
    endtask

    // Runs one frame starting in the current cycle E. Expected strobes: exp_first, then every eff_div,
    // nine in total, truncated by an abort at E+abort_k. Ends in the first IDLE cycle after the frame.
    task automatic frame(input string name, input int clk_div_v, input int eff_div,
                         input int exp_first, input int exp_strobes, input int abort_k,
                         input int chg_k, input int chg_val, input bit exp_cfg);
        int last;
        int stop_k;
        int first_seen;
        int nstrobe;
        bit s_exp;
        bit d_exp;
        bit b_exp;
        bit c_exp;
        last       = exp_first + 8 * eff_div;
        stop_k     = (abort_k > 0) ? abort_k : last + 1;
        first_seen = -1;
        nstrobe    = 0;
        sif.clk_div      = 8'(clk_div_v);
        sif.enable_timer = 1'b1;
        for (int k = 1; k <= stop_k + 1; k++) begin
            tick();
            if (k == chg_k) sif.clk_div = 8'(chg_val);
            s_exp = (k >= exp_first) && (((k - exp_first) % eff_div) == 0) && (k <= last) && (k <= stop_k);
            d_exp = (abort_k == 0) && (k >= last) && (k <= stop_k);
            b_exp = (k <= stop_k);
            c_exp = exp_cfg && (k == 1);
            check($sformatf("%s strobe E+%0d", name, k), sif.shift_strobe, s_exp);
            check($sformatf("%s done E+%0d", name, k),   sif.packet_done,  d_exp);
            check($sformatf("%s busy E+%0d", name, k),   sif.busy,         b_exp);
            check($sformatf("%s cfg_error E+%0d", name, k), sif.cfg_error, c_exp);
            if (sif.shift_strobe === 1'b1) begin
                nstrobe++;
                if (first_seen < 0) first_seen = k;
            end
            if (k == stop_k) sif.enable_timer = 1'b0;
        end
        check({name, " first strobe cycle"}, first_seen, exp_first);
        check({name, " strobe count"},       nstrobe,    exp_strobes);
    endtask

    initial begin
        n_rst            = 1'b0;
        sif.enable_timer = 1'b0;
        sif.clk_div      = 8'd10;
        tick();
        tick();
        check_outputs_zero("reset");
        n_rst = 1'b1;
        tick();
        check_outputs_zero("idle after reset");

        // Reset mid-frame: strobe is high at E+24 in BIT; async reset must clear it at once.
        sif.clk_div      = 8'd10;
        sif.enable_timer = 1'b1;
        for (int k = 1; k <= 24; k++) tick();
        check("midreset strobe before", sif.shift_strobe, 1);
        check("midreset busy before",   sif.busy,         1);
        #2;
        n_rst = 1'b0;
        #1;
        check_outputs_zero("midreset asserted");
        sif.enable_timer = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("post-reset strobe %0d", k), sif.shift_strobe, 0);
            check($sformatf("post-reset busy %0d", k),   sif.busy,         0);
        end

        // Nominal div=10: first_len=13, strobes E+14..E+94, done E+94, enable dropped E+95.
        frame("nominal", 10, 10, 14, 9, 0, 0, 0, 1'b0);
        // Back-to-back, re-enabled in the first IDLE cycle: div=8, first_len=10, first strobe E'+11.
        frame("b2b", 8, 8, 11, 9, 0, 0, 0, 1'b0);
        tick();
        tick();
        // Illegal divisor 3 falls back to 10.
        frame("illegal", 3, 10, 14, 9, 0, 0, 0, 1'b1);
        tick();
        // Abort: div=16, first_len=22, single strobe at E+23, enable dropped at E+30.
        frame("abort", 16, 16, 23, 1, 30, 0, 0, 1'b0);
        tick();
        check_outputs_zero("after abort");
        // Config change at E+5 to 20 is ignored: div=12, first_len=16.
        frame("cfgchg", 12, 12, 17, 9, 0, 5, 20, 1'b0);
        tick();
        check_outputs_zero("final idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
